// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_fwft
// Description : Single-clock FIFO with registered status flags, sticky
//               overflow/underflow error flags and a selectable read mode:
//               standard (registered read data) or first-word-fall-through.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft #(
  parameter int DATA_WIDTH       = 24,
  parameter int DEPTH_WIDTH      = 12,
  parameter int FWFT_EN          = 0,
  parameter int ALMOST_FULL_NUM  = 4090,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_empty,
  output logic                  almost_empty,
  output logic [DEPTH_WIDTH:0]  water_level,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int                   C_DEPTH      = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] C_FULL_LEVEL = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [DEPTH_WIDTH:0] C_LVL_ONE    = {{DEPTH_WIDTH{1'b0}}, 1'b1};
  localparam logic [DEPTH_WIDTH-1:0] C_PTR_ONE  = {{(DEPTH_WIDTH-1){1'b0}}, 1'b1};
  localparam int unsigned          C_AF         = ALMOST_FULL_NUM;
  localparam int unsigned          C_AE         = ALMOST_EMPTY_NUM;

  logic [DATA_WIDTH-1:0]  mem_q [C_DEPTH];
  logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_WIDTH:0]   level_q, level_d;
  logic                   wr_full_q, wr_full_d;
  logic                   almost_full_q, almost_full_d;
  logic                   rd_empty_q, rd_empty_d;
  logic                   almost_empty_q, almost_empty_d;
  logic                   overflow_q, overflow_d;
  logic                   underflow_q, underflow_d;
  logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
  logic                   wr_accept;
  logic                   rd_accept;
  logic                   mem_pop;
  logic [DATA_WIDTH-1:0]  mem_head;

  // Acceptance uses only the registered flags, so a full FIFO rejects a
  // write even when a read frees a slot in the same cycle (and vice versa).
  assign wr_accept = wr_en & ~wr_full_q;
  assign rd_accept = rd_en & ~rd_empty_q;
  assign mem_head  = mem_q[rd_ptr_q];
  assign rd_ptr_d  = mem_pop ? rd_ptr_q + C_PTR_ONE : rd_ptr_q;

  // Level, write pointer, status flags and sticky error flags next-state
  always_comb begin
    level_d = level_q;
    if (wr_accept && !rd_accept) begin
      level_d = level_q + C_LVL_ONE;
    end else if (!wr_accept && rd_accept) begin
      level_d = level_q - C_LVL_ONE;
    end
    wr_ptr_d       = wr_accept ? wr_ptr_q + C_PTR_ONE : wr_ptr_q;
    wr_full_d      = (level_d == C_FULL_LEVEL);
    almost_full_d  = (32'(level_d) >= C_AF);
    almost_empty_d = (32'(level_d) <= C_AE);
    // A new error wins over a simultaneous clear
    overflow_d     = (overflow_q  & ~clr_err) | (wr_en & wr_full_q);
    underflow_d    = (underflow_q & ~clr_err) | (rd_en & rd_empty_q);
  end

  generate
    if (FWFT_EN != 0) begin : g_fwft
      // The output register holds the head word; words still in the array
      // are the level minus the one held in the output register.
      logic [DEPTH_WIDTH:0] mem_words;

      // Prefetch into the output register when it is empty or being popped
      always_comb begin
        mem_words  = level_q - {{DEPTH_WIDTH{1'b0}}, ~rd_empty_q};
        mem_pop    = (mem_words != '0) && (rd_empty_q || rd_accept);
        rd_data_d  = mem_pop ? mem_head : rd_data_q;
        rd_empty_d = ~(mem_pop | (~rd_empty_q & ~rd_accept));
      end
    end else begin : g_std
      // Registered read: data appears the cycle after an accepted read
      always_comb begin
        mem_pop    = rd_accept;
        rd_data_d  = rd_accept ? mem_head : rd_data_q;
        rd_empty_d = (level_d == '0);
      end
    end
  endgenerate

  // Storage array; contents are never reset
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Control and status registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      wr_full_q      <= 1'b0;
      almost_full_q  <= 1'b0;
      rd_empty_q     <= 1'b1;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      wr_full_q      <= wr_full_d;
      almost_full_q  <= almost_full_d;
      rd_empty_q     <= rd_empty_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
      rd_data_q      <= rd_data_d;
    end
  end

  assign wr_full      = wr_full_q;
  assign almost_full  = almost_full_q;
  assign rd_empty     = rd_empty_q;
  assign almost_empty = almost_empty_q;
  assign water_level  = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign rd_data      = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_fwft
// Description : Self-checking bench for sync_fifo_fwft. One standard-mode and
//               one FWFT-mode instance share all stimulus; each is compared
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_fwft;

  localparam int DW    = 24;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFN   = 14;
  localparam int AEN   = 2;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b1;
  logic          wr_en   = 1'b0;
  logic          rd_en   = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] wr_data = '0;

  logic          s_full, s_af, s_empty, s_ae, s_ovf, s_udf;
  logic [DW-1:0] s_data;
  logic [AW:0]   s_level;
  logic          f_full, f_af, f_empty, f_ae, f_ovf, f_udf;
  logic [DW-1:0] f_data;
  logic [AW:0]   f_level;

  always #5 clk = ~clk;

  sync_fifo_fwft #(
    .DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .FWFT_EN(0),
    .ALMOST_FULL_NUM(AFN), .ALMOST_EMPTY_NUM(AEN)
  ) u_std (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(s_full), .almost_full(s_af), .rd_en(rd_en), .rd_data(s_data),
    .rd_empty(s_empty), .almost_empty(s_ae), .water_level(s_level),
    .overflow(s_ovf), .underflow(s_udf), .clr_err(clr_err)
  );

  sync_fifo_fwft #(
    .DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .FWFT_EN(1),
    .ALMOST_FULL_NUM(AFN), .ALMOST_EMPTY_NUM(AEN)
  ) u_fwft (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(f_full), .almost_full(f_af), .rd_en(rd_en), .rd_data(f_data),
    .rd_empty(f_empty), .almost_empty(f_ae), .water_level(f_level),
    .overflow(f_ovf), .underflow(f_udf), .clr_err(clr_err)
  );

  // Reference model. FWFT entries carry the edge number after which they can
  // be seen at the output: one edge after being written, and no earlier than
  // the edge on which the previous head was popped.
  typedef struct {
    logic [DW-1:0] data;
    int            ready;
  } fent_t;

  logic [DW-1:0] q_s[$];
  fent_t         q_f[$];
  logic [DW-1:0] m_s_data;
  bit            m_s_ovf, m_s_udf, m_f_ovf, m_f_udf;
  int            n_edge   = 0;
  int            n_checks = 0;
  int            n_pass   = 0;

  function automatic bit f_vis();
    return (q_f.size() > 0) && (q_f[0].ready <= n_edge);
  endfunction

  // Expected {level, full, almost_full, empty, almost_empty, overflow, underflow}
  function automatic logic [10:0] exp_s();
    int n = q_s.size();
    return {5'(n), n == DEPTH, n >= AFN, n == 0, n <= AEN, m_s_ovf, m_s_udf};
  endfunction

  function automatic logic [10:0] exp_f();
    int n = q_f.size();
    return {5'(n), n == DEPTH, n >= AFN, !f_vis(), n <= AEN, m_f_ovf, m_f_udf};
  endfunction

  task automatic model_reset();
    q_s.delete();
    q_f.delete();
    m_s_data = '0;
    m_s_ovf  = 1'b0;
    m_s_udf  = 1'b0;
    m_f_ovf  = 1'b0;
    m_f_udf  = 1'b0;
  endtask

  // Drive one cycle of stimulus, advance one edge, update the model, and
  // leave time 1 unit past the edge for sampling.
  task automatic tick(input bit w, input bit r, input logic [DW-1:0] d, input bit c);
    bit    s_wa, s_ra, f_wa, f_ra;
    fent_t e;
    s_wa = w && (q_s.size() < DEPTH);
    s_ra = r && (q_s.size() != 0);
    f_wa = w && (q_f.size() < DEPTH);
    f_ra = r && f_vis();
    wr_en   = w;
    rd_en   = r;
    wr_data = d;
    clr_err = c;
    @(posedge clk);
    n_edge++;
    m_s_ovf = (m_s_ovf && !c) || (w && !s_wa);
    m_s_udf = (m_s_udf && !c) || (r && !s_ra);
    m_f_ovf = (m_f_ovf && !c) || (w && !f_wa);
    m_f_udf = (m_f_udf && !c) || (r && !f_ra);
    if (s_ra) m_s_data = q_s.pop_front();
    if (s_wa) q_s.push_back(d);
    if (f_ra) begin
      q_f.delete(0);
      if (q_f.size() > 0 && q_f[0].ready < n_edge) begin
        e       = q_f[0];
        e.ready = n_edge;
        q_f[0]  = e;
      end
    end
    if (f_wa) begin
      e.data  = d;
      e.ready = n_edge + 1;
      q_f.push_back(e);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({s_level, s_full, s_af, s_empty, s_ae, s_ovf, s_udf} !== 11'b00000_0_0_1_1_0_0)
      $display("FAIL reset_flags_std got %b exp %b", {s_level, s_full, s_af, s_empty, s_ae, s_ovf, s_udf}, 11'b00000_0_0_1_1_0_0);
    else n_pass++;
    n_checks++;
    if ({f_level, f_full, f_af, f_empty, f_ae, f_ovf, f_udf} !== 11'b00000_0_0_1_1_0_0)
      $display("FAIL reset_flags_fwft got %b exp %b", {f_level, f_full, f_af, f_empty, f_ae, f_ovf, f_udf}, 11'b00000_0_0_1_1_0_0);
    else n_pass++;
    n_checks++;
    if ({s_data, f_data} !== 48'h0)
      $display("FAIL reset_rd_data got %h exp 0", {s_data, f_data});
    else n_pass++;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      tick(1'b1, 1'b0, 24'(i), 1'b0);
      n_checks++;
      if ({s_level, s_full, s_af, s_empty, s_ae, s_ovf, s_udf} !== exp_s())
        $display("FAIL fill_std word %0d got %b exp %b", i, {s_level, s_full, s_af, s_empty, s_ae, s_ovf, s_udf}, exp_s());
      else n_pass++;
      n_checks++;
      if ({f_level, f_full, f_af, f_empty, f_ae, f_ovf, f_udf} !== exp_f())
        $display("FAIL fill_fwft word %0d got %b exp %b", i, {f_level, f_full, f_af, f_empty, f_ae, f_ovf, f_udf}, exp_f());
      else n_pass++;
    end
    n_checks++;
    if ({s_level, s_full, s_af} !== {5'd16, 1'b1, 1'b1})
      $display("FAIL fill_full_std got %b exp %b", {s_level, s_full, s_af}, {5'd16, 1'b1, 1'b1});
    else n_pass++;
    // 17th write is rejected
    tick(1'b1, 1'b0, 24'h000011, 1'b0);
    n_checks++;
    if ({s_level, s_ovf, f_level, f_ovf} !== {5'd16, 1'b1, 5'd16, 1'b1})
      $display("FAIL fill_overflow got %b exp %b", {s_level, s_ovf, f_level, f_ovf}, {5'd16, 1'b1, 5'd16, 1'b1});
    else n_pass++;
    // clr_err alone clears overflow
    tick(1'b0, 1'b0, '0, 1'b1);
    n_checks++;
    if ({s_ovf, f_ovf} !== {m_s_ovf, m_f_ovf} || s_ovf !== 1'b0)
      $display("FAIL clr_err_clears got %b exp %b", {s_ovf, f_ovf}, {m_s_ovf, m_f_ovf});
    else n_pass++;
    // clr_err together with a rejected write keeps overflow set
    tick(1'b1, 1'b0, 24'h000012, 1'b1);
    n_checks++;
    if ({s_ovf, f_ovf, s_level} !== {1'b1, 1'b1, 5'd16})
      $display("FAIL clr_err_concurrent got %b exp %b", {s_ovf, f_ovf, s_level}, {1'b1, 1'b1, 5'd16});
    else n_pass++;
    tick(1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_drain_std();
    for (int i = 1; i <= DEPTH; i++) begin
      tick(1'b0, 1'b1, '0, 1'b0);
      n_checks++;
      if (s_data !== 24'(i))
        $display("FAIL drain_data_std word %0d got %h exp %h", i, s_data, 24'(i));
      else n_pass++;
      n_checks++;
      if ({f_level, f_full, f_af, f_empty, f_ae, f_ovf, f_udf} !== exp_f() ||
          (f_vis() && f_data !== q_f[0].data))
        $display("FAIL drain_fwft word %0d got %b/%h exp %b", i, {f_level, f_full, f_af, f_empty, f_ae, f_ovf, f_udf}, f_data, exp_f());
      else n_pass++;
    end
    n_checks++;
    if ({s_level, s_empty, s_ae} !== {5'd0, 1'b1, 1'b1})
      $display("FAIL drain_empty_std got %b exp %b", {s_level, s_empty, s_ae}, {5'd0, 1'b1, 1'b1});
    else n_pass++;
    tick(1'b0, 1'b1, '0, 1'b0);
    n_checks++;
    if ({s_udf, f_udf, s_data} !== {1'b1, 1'b1, 24'h000010})
      $display("FAIL drain_underflow got %b/%b data %h exp 1/1 data 000010", s_udf, f_udf, s_data);
    else n_pass++;
    tick(1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_fwft_single();
    tick(1'b1, 1'b0, 24'hABCDEF, 1'b0);
    n_checks++;
    if (f_empty !== 1'b1)
      $display("FAIL fwft_latency_early got rd_empty=%b exp 1", f_empty);
    else n_pass++;
    tick(1'b0, 1'b0, '0, 1'b0);
    n_checks++;
    if ({f_empty, f_data} !== {1'b0, 24'hABCDEF})
      $display("FAIL fwft_head got empty=%b data=%h exp empty=0 data=abcdef", f_empty, f_data);
    else n_pass++;
    tick(1'b0, 1'b1, '0, 1'b0);
    n_checks++;
    if ({f_empty, f_level, s_data, s_empty} !== {1'b1, 5'd0, 24'hABCDEF, 1'b1})
      $display("FAIL fwft_pop got %b/%0d std %h/%b exp 1/0 std abcdef/1", f_empty, f_level, s_data, s_empty);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < DEPTH; i++) tick(1'b1, 1'b0, 24'($urandom()), 1'b0);
    // Both requests at full: read wins, write rejected
    tick(1'b1, 1'b1, 24'($urandom()), 1'b0);
    n_checks++;
    if ({s_level, s_ovf, f_level, f_ovf} !== {5'd15, 1'b1, 5'd15, 1'b1})
      $display("FAIL simul_full got %b exp %b", {s_level, s_ovf, f_level, f_ovf}, {5'd15, 1'b1, 5'd15, 1'b1});
    else n_pass++;
    n_checks++;
    if (s_data !== m_s_data)
      $display("FAIL simul_full_data got %h exp %h", s_data, m_s_data);
    else n_pass++;
    tick(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b1, '0, 1'b0);
    n_checks++;
    if ({s_level, f_level} !== {5'd8, 5'd8})
      $display("FAIL simul_level8 got %0d/%0d exp 8/8", s_level, f_level);
    else n_pass++;
    for (int i = 0; i < 100; i++) begin
      tick(1'b1, 1'b1, 24'($urandom()), 1'b0);
      n_checks++;
      if ({s_level, s_data} !== {5'd8, m_s_data})
        $display("FAIL simul_stream_std cycle %0d got %0d/%h exp 8/%h", i, s_level, s_data, m_s_data);
      else n_pass++;
      n_checks++;
      if ({f_level, f_empty} !== {5'd8, 1'b0} || f_data !== q_f[0].data)
        $display("FAIL simul_stream_fwft cycle %0d got %0d/%b/%h exp 8/0/%h", i, f_level, f_empty, f_data, q_f[0].data);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      int wp = (i < 200) ? 70 : 30;
      bit w  = ($urandom_range(0, 99) < wp);
      bit r  = ($urandom_range(0, 99) < (100 - wp));
      bit c  = ($urandom_range(0, 99) < 5);
      tick(w, r, 24'($urandom()), c);
      n_checks++;
      if ({s_level, s_full, s_af, s_empty, s_ae, s_ovf, s_udf} !== exp_s() || s_data !== m_s_data)
        $display("FAIL random_std cycle %0d got %b/%h exp %b/%h", i, {s_level, s_full, s_af, s_empty, s_ae, s_ovf, s_udf}, s_data, exp_s(), m_s_data);
      else n_pass++;
      n_checks++;
      if ({f_level, f_full, f_af, f_empty, f_ae, f_ovf, f_udf} !== exp_f() ||
          (f_vis() && f_data !== q_f[0].data))
        $display("FAIL random_fwft cycle %0d got %b/%h exp %b", i, {f_level, f_full, f_af, f_empty, f_ae, f_ovf, f_udf}, f_data, exp_f());
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 64 && (q_s.size() > 0 || q_f.size() > 0); i++)
      tick(1'b0, 1'b1, '0, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 9; i++) tick(1'b1, 1'b0, 24'($urandom()), 1'b0);
    n_checks++;
    if ({s_level, f_level} !== {5'd9, 5'd9})
      $display("FAIL midreset_prelevel got %0d/%0d exp 9/9", s_level, f_level);
    else n_pass++;
    wr_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({s_level, s_full, s_af, s_empty, s_ae, s_ovf, s_udf, s_data} !== {11'b00000_0_0_1_1_0_0, 24'h0})
      $display("FAIL midreset_std got %b/%h exp 00000001100/000000", {s_level, s_full, s_af, s_empty, s_ae, s_ovf, s_udf}, s_data);
    else n_pass++;
    n_checks++;
    if ({f_level, f_full, f_af, f_empty, f_ae, f_ovf, f_udf, f_data} !== {11'b00000_0_0_1_1_0_0, 24'h0})
      $display("FAIL midreset_fwft got %b/%h exp 00000001100/000000", {f_level, f_full, f_af, f_empty, f_ae, f_ovf, f_udf}, f_data);
    else n_pass++;
    model_reset();
    #1;
    rst_n = 1'b1;
    tick(1'b1, 1'b0, 24'h123456, 1'b0);
    n_checks++;
    if ({s_level, f_level} !== {5'd1, 5'd1})
      $display("FAIL midreset_first_write got %0d/%0d exp 1/1", s_level, f_level);
    else n_pass++;
    tick(1'b0, 1'b0, '0, 1'b0);
    n_checks++;
    if ({f_empty, f_data} !== {1'b0, 24'h123456})
      $display("FAIL midreset_fwft_head got %b/%h exp 0/123456", f_empty, f_data);
    else n_pass++;
    tick(1'b0, 1'b1, '0, 1'b0);
    n_checks++;
    if (s_data !== 24'h123456)
      $display("FAIL midreset_std_read got %h exp 123456", s_data);
    else n_pass++;
  endtask

  initial begin
    model_reset();
    #2;
    test_reset();
    test_fill();
    test_drain_std();
    test_fwft_single();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_fifo_fwft.md
SYNC_FIFO_FWFT -- requirements
Module: sync_fifo_fwft

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 24: word width in bits, legal 1..1152.
- REQ-002 SHALL have parameter DEPTH_WIDTH, default 12: capacity is 2^DEPTH_WIDTH words, legal 4..16.
- REQ-003 SHALL have parameter FWFT_EN, default 0: 0 selects standard read mode, 1 selects first-word-fall-through mode.
- REQ-004 SHALL have parameter ALMOST_FULL_NUM, default 4090: almost-full threshold in words.
- REQ-005 SHALL have parameter ALMOST_EMPTY_NUM, default 4: almost-empty threshold in words.
- REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
- REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
- REQ-008 SHALL have port wr_en, input, 1 bit: write request.
- REQ-009 SHALL have port wr_data, input, DATA_WIDTH bits: write word.
- REQ-010 SHALL have port wr_full, output, 1 bit: FIFO full.
- REQ-011 SHALL have port almost_full, output, 1 bit: level at or above ALMOST_FULL_NUM.
- REQ-012 SHALL have port rd_en, input, 1 bit: read request or pop.
- REQ-013 SHALL have port rd_data, output, DATA_WIDTH bits: read word.
- REQ-014 SHALL have port rd_empty, output, 1 bit: no word available to read.
- REQ-015 SHALL have port almost_empty, output, 1 bit: level at or below ALMOST_EMPTY_NUM.
- REQ-016 SHALL have port water_level, output, DEPTH_WIDTH+1 bits: words written and not yet read.
- REQ-017 SHALL have port overflow, output, 1 bit: sticky flag for a rejected write.
- REQ-018 SHALL have port underflow, output, 1 bit: sticky flag for a rejected read.
- REQ-019 SHALL have port clr_err, input, 1 bit: synchronous clear of overflow and underflow.

Function
- REQ-020 A write SHALL be accepted iff wr_en=1 and wr_full=0 at the clock edge; a read SHALL be accepted iff rd_en=1 and rd_empty=0.
- REQ-021 Words SHALL be returned in write order; pointers SHALL wrap modulo 2^DEPTH_WIDTH with no loss or duplication.
- REQ-022 water_level SHALL update the cycle after an accepted operation: +1 for write only, -1 for read only, unchanged for both, range 0..2^DEPTH_WIDTH.
- REQ-023 All flags SHALL be registered and derived from the updated water_level in that same cycle.
  - wr_full = (level == 2^DEPTH_WIDTH).
  - almost_full = (level >= ALMOST_FULL_NUM).
  - almost_empty = (level <= ALMOST_EMPTY_NUM).
- REQ-024 With FWFT_EN=0: rd_empty = (level == 0); rd_data SHALL present the read word one cycle after an accepted read and hold otherwise.
- REQ-025 With FWFT_EN=1: rd_data SHALL present the head word whenever rd_empty=0, and an accepted read SHALL advance rd_data to the next word in the following cycle.
  - After a write into an empty FIFO, rd_empty SHALL deassert exactly 2 cycles later.
  - Continuous rd_en SHALL sustain 1 word per cycle.
- REQ-026 Simultaneous write and read when full SHALL accept the read and reject the write (flags are sampled before update).
- REQ-027 Simultaneous write and read when rd_empty=1 SHALL accept the write and reject the read.
- REQ-028 A rejected write SHALL set overflow on the next cycle; a rejected read SHALL set underflow on the next cycle. Both SHALL stay set until clr_err=1.
- REQ-029 If clr_err=1 and a new error occur in the same cycle, the flag SHALL remain set.
- REQ-030 Rejected operations SHALL NOT change the pointers, the level or rd_data.

Reset
- REQ-031 While rst_n=0, the following outputs SHALL be forced immediately, independent of clk:
  - water_level=0, pointers=0;
  - wr_full=0, almost_full=0;
  - rd_empty=1, almost_empty=1;
  - overflow=0, underflow=0;
  - rd_data=0.
- REQ-032 Reset asserted mid-operation SHALL discard all stored words; the first write after rst_n rises SHALL be accepted on the first clock edge.
- REQ-033 Memory contents SHALL NOT require reset.

Verification (DATA_WIDTH=24, DEPTH_WIDTH=4, ALMOST_FULL_NUM=14, ALMOST_EMPTY_NUM=2)
- REQ-034 Fill test: write 16 words 0x000001..0x000010 -> almost_full rises after word 14, wr_full after word 16, water_level=16; a 17th write sets overflow and level stays 16.
- REQ-035 Standard drain (FWFT_EN=0): read 16 words -> data 0x000001..0x000010 in order, each 1 cycle after rd_en; rd_empty=1 and almost_empty=1 at the end; one extra read sets underflow.
- REQ-036 FWFT (FWFT_EN=1): single write of 0xABCDEF into an empty FIFO -> rd_empty=0 and rd_data=0xABCDEF 2 cycles later without rd_en; a pop returns rd_empty to 1.
- REQ-037 Simultaneous traffic: at level 16, assert wr_en and rd_en together -> read accepted, write rejected, overflow set; at level 8, both for 100 cycles -> level stays 8 and pointers wrap with data intact.
- REQ-038 Reset mid-stream: level 9, drive rst_n=0 between edges -> outputs take reset values immediately; after release, write 0x123456 -> it is the next word read.
- REQ-039 clr_err: pulse with overflow=1 -> flag 0 next cycle; pulse concurrent with a rejected write -> flag remains 1.
